// File: rtl/mdu_iterative.sv
// mdu_iterative - RV32M multiply/divide unit; radix-2 shift-add multiply and restoring divide.
// SELECT codes: 5'b01_fff, where fff is the RV32M funct3 (MUL=0x08 .. REMU=0x0F).
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fix_q, fix_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [2:0]        f3;
  logic              is_m, is_div, sgn1, sgn2, in_s1, in_s2, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2, spec_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   quo_n, rem_n, fix_res;

  always_comb begin
    f3     = SELECT[2:0];
    is_m   = (SELECT[4:3] == 2'b01);
    is_div = f3[2];
    sgn1   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    sgn2   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    in_s1  = sgn1 & DATA1[XLEN-1];
    in_s2  = sgn2 & DATA2[XLEN-1];
    mag1   = in_s1 ? -DATA1 : DATA1;
    mag2   = in_s2 ? -DATA2 : DATA2;
    div0   = is_div && (DATA2 == '0);
    ovf    = ((f3 == 3'd4) || (f3 == 3'd6)) && (DATA1 == {1'b1, {(XLEN-1){1'b0}}})
             && (DATA2 == '1);
    if (div0) spec_res = f3[1] ? DATA1 : '1;
    else      spec_res = f3[1] ? '0 : DATA1;

    // Multiply: hi accumulates the multiplicand while lo shifts the multiplier out.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift - {1'b0, opb_q};

    prod_n = (s1_q ^ s2_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_n  = (s1_q ^ s2_q) ? -lo_q : lo_q;
    rem_n  = s1_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:             fix_res = prod_n[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_n[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = quo_n;
      default:          fix_res = rem_n;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    cnt_d    = cnt_q;
    fix_d    = fix_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !FLUSH && is_m) begin
          op_d  = f3;
          s1_d  = in_s1;
          s2_d  = in_s2;
          opa_d = mag1;
          opb_d = mag2;
          if (div0 || ovf) begin
            result_d = spec_res;
            state_d  = FIN;
            done_d   = 1'b1;
          end else begin
            hi_d    = '0;
            lo_d    = is_div ? mag1 : mag2;
            cnt_d   = '0;
            fix_d   = 1'b0;
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        if (FLUSH) begin
          state_d = IDLE;
        end else if (fix_q) begin
          result_d = fix_res;
          state_d  = FIN;
          done_d   = 1'b1;
        end else begin
          if (op_q[2]) begin
            hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d  = cnt_q + 1'b1;
          fix_d  = (cnt_q == CNT_LAST);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      fix_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      fix_q    <= fix_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule
